// File: rtl/router_pkg.sv
// router_pkg: shared port-ID width, arbiter state enum and round-robin pick helper
package router_pkg;

    localparam int PORT_ID_W = 8;

    typedef enum logic {IDLE, ACTIVE} arb_state_t;

    // Highest priority goes to last+1, lowest to last itself; descending k lets
    // the nearer candidate overwrite the farther one.
    function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [3:0] g;
        logic [1:0] idx;
        g = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) g = 4'b1 << idx;
        end
        return g;
    endfunction

endpackage

// File: rtl/router_rr_pick4.sv
// router_rr_pick4: 4-way rotating priority encoder
//   req[3:0]    requesting sources
//   last[1:0]   previously granted source (lowest priority this round)
//   onehot[3:0] selected source, zero when nothing requests
//   any         some source requests
module router_rr_pick4
    import router_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] onehot,
    output logic       any
);

    assign onehot = rr_pick(req, last);
    assign any    = |req;

endmodule

// File: rtl/router_arb4_rr.sv
// router_arb4_rr: round-robin frame arbiter, 4 sources onto one output port
//   CLK, RST     clock, asynchronous active-high reset
//   DEST         per-source 8-bit destination, source i at [8i+7:8i]
//   D_SOF        per-source start of frame, held until accepted
//   D_EOF        per-source end-of-frame beat marker
//   D_VALID      per-source beat valid
//   Q_BP         sink backpressure
//   D_BP         per-source backpressure (combinational)
//   GRANT        one-hot registered grant, drives the output datapath mux select
//   GRANT_SOF    pulse in the first granted cycle
//   BUSY         a frame holds the port
//   TIMEOUT_ERR  pulse on forced release; only with ROUTER_ARB_TIMEOUT_EN
// Optional feature: define ROUTER_ARB_TIMEOUT_EN to release a grant after
// MaxBeats consecutive cycles without an accepted beat.
module router_arb4_rr
    import router_pkg::*;
#(
    parameter int NumPorts = 4,
    parameter int PortNo   = 1,
    parameter int MaxBeats = 256
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NumPorts*8-1:0] DEST,
    input  logic [NumPorts-1:0]   D_SOF,
    input  logic [NumPorts-1:0]   D_EOF,
    input  logic [NumPorts-1:0]   D_VALID,
    input  logic                  Q_BP,
    output logic [NumPorts-1:0]   D_BP,
    output logic [NumPorts-1:0]   GRANT,
    output logic                  GRANT_SOF,
    output logic                  BUSY,
    output logic                  TIMEOUT_ERR
);

    arb_state_t          state, state_n;
    logic [NumPorts-1:0] req, pick, grant_n;
    logic [1:0]          last, last_n;
    logic                any, sof_n, acc, eof_acc, expire;

    for (genvar i = 0; i < NumPorts; i++) begin : g_req
        assign req[i] = D_SOF[i] & (DEST[8*i +: PORT_ID_W] == PORT_ID_W'(PortNo));
    end

    router_rr_pick4 u_pick (
        .req    (req),
        .last   (last),
        .onehot (pick),
        .any    (any)
    );

    assign acc     = |(GRANT & D_VALID) & ~Q_BP;
    assign eof_acc = acc & |(GRANT & D_EOF);
    assign D_BP    = (req & ~GRANT) | (GRANT & {NumPorts{Q_BP}});
    assign BUSY    = state == ACTIVE;

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int BW = $clog2(MaxBeats) + 1;
    logic [BW-1:0] beats;

    // beats stays 0 in IDLE, so every grant starts counting from 0
    assign expire = BUSY & ~acc & (beats == BW'(MaxBeats - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            beats       <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            beats       <= (!BUSY || acc) ? '0 : beats + 1'b1;
            TIMEOUT_ERR <= expire;
        end
    end
`else
    assign expire      = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    always_comb begin
        state_n = state;
        grant_n = GRANT;
        last_n  = last;
        sof_n   = 1'b0;
        if (state == IDLE) begin
            if (any) begin
                state_n = ACTIVE;
                grant_n = pick;
                last_n  = {pick[3] | pick[2], pick[3] | pick[1]};
                sof_n   = 1'b1;
            end
        end else if (eof_acc || expire) begin
            state_n = IDLE;
            grant_n = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            GRANT     <= '0;
            GRANT_SOF <= 1'b0;
            last      <= 2'd3;
        end else begin
            state     <= state_n;
            GRANT     <= grant_n;
            GRANT_SOF <= sof_n;
            last      <= last_n;
        end
    end

endmodule
